// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment states and default tuning.
// Used by both the decoder and the encoder.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTL_11 = 10'b1010101011;

    localparam int SEARCH_WIN_DEF  = 4096;
    localparam int TOKEN_RUN_DEF   = 32;
    localparam int SLIP_SETTLE_DEF = 8;
    localparam int LOCK_WIN_DEF    = 8192;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } align_state_t;

    function automatic logic is_token(input logic [9:0] sym);
        return (sym == TMDS_CTL_00) || (sym == TMDS_CTL_01) ||
               (sym == TMDS_CTL_10) || (sym == TMDS_CTL_11);
    endfunction

    function automatic logic [1:0] token_ctl(input logic [9:0] sym);
        logic [1:0] c;
        c = 2'b00;
        if (sym == TMDS_CTL_01) c = 2'b01;
        if (sym == TMDS_CTL_10) c = 2'b10;
        if (sym == TMDS_CTL_11) c = 2'b11;
        return c;
    endfunction

endpackage

// File: rtl/tmds_align.sv
// Word-boundary alignment: hunts for runs of control tokens, requests bitslips
// while none are found, and holds lock under a watchdog once they are.
module tmds_align
    import tmds_pkg::*;
#(
    parameter int SEARCH_WIN  = SEARCH_WIN_DEF,
    parameter int TOKEN_RUN   = TOKEN_RUN_DEF,
    parameter int SLIP_SETTLE = SLIP_SETTLE_DEF,
    parameter int LOCK_WIN    = LOCK_WIN_DEF
) (
    input  logic       pixel_clk,
    input  logic       resetn,
    input  logic       tok_p0,
    output logic       aligned,
    output logic       bitslip,
    output logic [3:0] slip_cnt
);

    localparam int WIN_W = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
    localparam int RUN_W = $clog2(TOKEN_RUN + 1);
    localparam int SET_W = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;
    localparam int WD_W  = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WIN - 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(TOKEN_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TOKEN_RUN - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LOCK_WIN - 1);

    align_state_t     state, state_d;
    logic [WIN_W-1:0] win_cnt, win_d;
    logic [RUN_W-1:0] tok_cnt, tok_d;
    logic [SET_W-1:0] set_cnt, set_d;
    logic [WD_W-1:0]  wd_cnt, wd_d;
    logic [3:0]       slip_d;
    logic             run;

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            state    <= SEARCH;
            win_cnt  <= '0;
            tok_cnt  <= '0;
            set_cnt  <= '0;
            wd_cnt   <= '0;
            slip_cnt <= '0;
        end else begin
            state    <= state_d;
            win_cnt  <= win_d;
            tok_cnt  <= tok_d;
            set_cnt  <= set_d;
            wd_cnt   <= wd_d;
            slip_cnt <= slip_d;
        end
    end

    always_comb begin
        run     = tok_p0 && (tok_cnt == RUN_LAST);
        tok_d   = tok_p0 ? ((tok_cnt == RUN_FULL) ? tok_cnt : tok_cnt + RUN_W'(1)) : '0;
        state_d = state;
        win_d   = '0;
        set_d   = '0;
        wd_d    = '0;
        slip_d  = slip_cnt;
        bitslip = 1'b0;
        case (state)
            SEARCH: begin
                // A completed run wins over an expiring window in the same cycle.
                if (run) begin
                    state_d = LOCKED;
                end else if (win_cnt == WIN_LAST) begin
                    bitslip = 1'b1;
                    slip_d  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                    tok_d   = '0;
                    state_d = SLIP_WAIT;
                end else begin
                    win_d = win_cnt + WIN_W'(1);
                end
            end
            SLIP_WAIT: begin
                tok_d = '0;
                if (set_cnt == SET_LAST) state_d = SEARCH;
                else                     set_d   = set_cnt + SET_W'(1);
            end
            LOCKED: begin
                if (!run) begin
                    if (wd_cnt == WD_LAST) begin
                        state_d = SEARCH;
                        tok_d   = '0;
                    end else begin
                        wd_d = wd_cnt + WD_W'(1);
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign aligned = (state == LOCKED);

endmodule

// File: rtl/tmds_decode.sv
// TMDS channel decoder: one register on the raw symbol, one on the decoded
// pixel/control result, gated by the alignment state.
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int SEARCH_WIN  = SEARCH_WIN_DEF,
    parameter int TOKEN_RUN   = TOKEN_RUN_DEF,
    parameter int SLIP_SETTLE = SLIP_SETTLE_DEF,
    parameter int LOCK_WIN    = LOCK_WIN_DEF
) (
    input  logic       pixel_clk,
    input  logic       resetn,
    input  logic [9:0] tmds_data,
    output logic [7:0] pdata,
    output logic [1:0] ctl,
    output logic       active,
    output logic       aligned,
    output logic       bitslip,
    output logic [3:0] slip_cnt
);

    function automatic logic [7:0] decode_data(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] b;
        d    = q[9] ? ~q[7:0] : q[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++)
            b[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return b;
    endfunction

    logic [9:0] sym_p0;
    logic       vld_p0;
    logic       tok_p0;

    // Stage p0: capture the raw symbol.
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            sym_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            sym_p0 <= tmds_data;
            vld_p0 <= 1'b1;
        end
    end

    assign tok_p0 = vld_p0 && is_token(sym_p0);

    tmds_align #(
        .SEARCH_WIN (SEARCH_WIN),
        .TOKEN_RUN  (TOKEN_RUN),
        .SLIP_SETTLE(SLIP_SETTLE),
        .LOCK_WIN   (LOCK_WIN)
    ) u_align (
        .pixel_clk(pixel_clk),
        .resetn   (resetn),
        .tok_p0   (tok_p0),
        .aligned  (aligned),
        .bitslip  (bitslip),
        .slip_cnt (slip_cnt)
    );

    // Stage p1: decoded outputs; ctl holds across data periods.
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            pdata  <= '0;
            ctl    <= '0;
            active <= 1'b0;
        end else if (!aligned || !vld_p0) begin
            pdata  <= '0;
            ctl    <= '0;
            active <= 1'b0;
        end else if (tok_p0) begin
            pdata  <= '0;
            ctl    <= token_ctl(sym_p0);
            active <= 1'b0;
        end else begin
            pdata  <= decode_data(sym_p0);
            active <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmds_decode.sv
// Bench for tmds_decode: a TMDS encoder and deserializer model drive the DUT,
// expectations come from the token/decode/alignment rules.
module tb_tmds_decode;

    localparam int SEARCH_WIN  = 4096;
    localparam int TOKEN_RUN   = 32;
    localparam int SLIP_SETTLE = 8;
    localparam int LOCK_WIN    = 8192;

    logic       pixel_clk = 1'b0;
    logic       resetn;
    logic [9:0] tmds_data;
    logic [7:0] pdata;
    logic [1:0] ctl;
    logic       active;
    logic       aligned;
    logic       bitslip;
    logic [3:0] slip_cnt;

    int n_tests;
    int n_fail;
    int cyc;

    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};

    always #5 pixel_clk = ~pixel_clk;

    tmds_decode #(
        .SEARCH_WIN (SEARCH_WIN),
        .TOKEN_RUN  (TOKEN_RUN),
        .SLIP_SETTLE(SLIP_SETTLE),
        .LOCK_WIN   (LOCK_WIN)
    ) dut (
        .pixel_clk(pixel_clk),
        .resetn   (resetn),
        .tmds_data(tmds_data),
        .pdata    (pdata),
        .ctl      (ctl),
        .active   (active),
        .aligned  (aligned),
        .bitslip  (bitslip),
        .slip_cnt (slip_cnt)
    );

    // Transition-minimising stage followed by optional DC inversion.
    function automatic logic [9:0] enc(input logic [7:0] b, input logic xor_mode, input logic inv);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++)
            q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        return {inv, xor_mode, inv ? ~q : q};
    endfunction

    function automatic int tok_index(input logic [9:0] s);
        for (int i = 0; i < 4; i++)
            if (s == tok_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        do
            s = enc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (tok_index(s) >= 0);
        return s;
    endfunction

    // Word seen by a deserializer whose boundary sits 'off' bits into a periodic stream.
    function automatic logic [9:0] rot(input logic [9:0] t, input int off);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) w[j] = t[(j + off) % 10];
        return w;
    endfunction

    task automatic step(input logic [9:0] s);
        @(negedge pixel_clk);
        tmds_data = s;
        @(posedge pixel_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        tmds_data = '0;
        repeat (2) @(posedge pixel_clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        tmds_data = tok_tab[0];
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({pdata, ctl, active, aligned, bitslip, slip_cnt} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%h required 0", {pdata, ctl, active, aligned, bitslip, slip_cnt});
        end
        repeat (3) @(posedge pixel_clk);
        #1;
        n_tests++;
        if ({pdata, ctl, active, aligned, bitslip, slip_cnt} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%h required 0", {pdata, ctl, active, aligned, bitslip, slip_cnt});
        end
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_aligned_lock();
        int run_len, exp_rise, rise, slips, drops;
        logic [9:0] s;
        do_reset();
        run_len = 0; exp_rise = -1; rise = -1; slips = 0; drops = 0;
        for (int line = 0; line < 2; line++) begin
            for (int x = 0; x < 1650; x++) begin
                s = (x < 1280) ? rand_data() : tok_tab[0];
                step(s);
                run_len = (tok_index(s) >= 0) ? run_len + 1 : 0;
                if (run_len == TOKEN_RUN && exp_rise < 0) exp_rise = cyc + 1;
                if (bitslip) slips++;
                if (aligned && rise < 0) rise = cyc;
                if (!aligned && rise >= 0) drops++;
            end
        end
        n_tests++;
        if (rise !== exp_rise) begin
            n_fail++; $display("FAIL lock_rise_cycle: got %0d required %0d", rise, exp_rise);
        end
        n_tests++;
        if (slips !== 0) begin
            n_fail++; $display("FAIL lock_no_slip: got %0d pulses required 0", slips);
        end
        n_tests++;
        if (slip_cnt !== 4'd0) begin
            n_fail++; $display("FAIL lock_slip_cnt: got %0d required 0", slip_cnt);
        end
        n_tests++;
        if (drops !== 0) begin
            n_fail++; $display("FAIL lock_held: aligned low on %0d cycles after lock, required 0", drops);
        end
    endtask

    task automatic test_decode_table();
        logic [9:0] seq[$];
        logic [7:0] src[$];
        logic [9:0] s;
        logic [7:0] e_pd;
        logic [1:0] last_ctl;
        logic       e_act;
        int         ti;
        int         tord [4] = '{3, 1, 2, 0};
        do_reset();
        for (int k = 0; k < 40; k++) step(tok_tab[0]);
        n_tests++;
        if (aligned !== 1'b1) begin
            n_fail++; $display("FAIL decode_prelock: aligned=%0b required 1", aligned);
        end
        for (int b = 0; b < 256; b++) begin
            for (int v = 0; v < 4; v++) begin
                seq.push_back(enc(8'(b), v[0], v[1]));
                src.push_back(8'(b));
            end
        end
        for (int t = 0; t < 4; t++) begin
            seq.push_back(tok_tab[tord[t]]);
            src.push_back(8'h00);
            seq.push_back(enc(8'(8'h30 + t), 1'b1, 1'b0));
            src.push_back(8'(8'h30 + t));
        end
        last_ctl = 2'b00;
        for (int n = 0; n <= seq.size(); n++) begin
            step((n < seq.size()) ? seq[n] : tok_tab[0]);
            if (n == 0) continue;
            s  = seq[n-1];
            ti = tok_index(s);
            if (ti >= 0) begin
                e_pd = 8'h00; e_act = 1'b0; last_ctl = 2'(ti);
            end else begin
                e_pd = src[n-1]; e_act = 1'b1;
            end
            n_tests++;
            if ({pdata, ctl, active, aligned} !== {e_pd, last_ctl, e_act, 1'b1}) begin
                n_fail++;
                $display("FAIL decode sym=%b: pdata=%h ctl=%b active=%b aligned=%b required pdata=%h ctl=%b active=%b aligned=1",
                         s, pdata, ctl, active, aligned, e_pd, last_ctl, e_act);
            end
        end
    endtask

    task automatic test_slip_search();
        int off, slips, last, min_gap;
        logic locked;
        do_reset();
        off = 3; slips = 0; last = -1; min_gap = 1 << 30; locked = 1'b0;
        for (int k = 0; k < 8 * (SEARCH_WIN + SLIP_SETTLE) + 200 && !locked; k++) begin
            step(rot(tok_tab[0], off));
            if (bitslip) begin
                if (last >= 0 && cyc - last < min_gap) min_gap = cyc - last;
                last = cyc;
                slips++;
                off = (off + 1) % 10;
            end
            if (aligned) locked = 1'b1;
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL slip_lock: aligned=%0b required 1 within budget", locked);
        end
        n_tests++;
        if (slips !== 7) begin
            n_fail++; $display("FAIL slip_pulses: got %0d required 7", slips);
        end
        n_tests++;
        if (slip_cnt !== 4'd7) begin
            n_fail++; $display("FAIL slip_cnt: got %0d required 7", slip_cnt);
        end
        n_tests++;
        if (min_gap < SEARCH_WIN + SLIP_SETTLE) begin
            n_fail++; $display("FAIL slip_spacing: got %0d required >= %0d", min_gap, SEARCH_WIN + SLIP_SETTLE);
        end
    endtask

    task automatic test_lock_loss();
        int rise, fall, slip;
        logic [10:0] outs;
        do_reset();
        rise = -1; fall = -1; slip = -1; outs = '1;
        for (int k = 0; k < 40; k++) begin
            step(tok_tab[0]);
            if (aligned && rise < 0) rise = cyc;
        end
        for (int k = 0; k < LOCK_WIN + SEARCH_WIN + 200 && slip < 0; k++) begin
            step(rand_data());
            if (!aligned && rise >= 0 && fall < 0) fall = cyc;
            if (bitslip) begin
                slip = cyc;
                outs = {pdata, ctl, active};
            end
        end
        n_tests++;
        if (rise !== TOKEN_RUN + 1) begin
            n_fail++; $display("FAIL loss_rise: got %0d required %0d", rise, TOKEN_RUN + 1);
        end
        n_tests++;
        if (fall < 0 || fall - rise !== LOCK_WIN) begin
            n_fail++; $display("FAIL loss_watchdog: locked for %0d cycles required %0d", fall - rise, LOCK_WIN);
        end
        n_tests++;
        if (slip < 0 || fall < 0 || slip - fall !== SEARCH_WIN - 1) begin
            n_fail++; $display("FAIL loss_search_slip: slip %0d cycles after fall required %0d", slip - fall, SEARCH_WIN - 1);
        end
        n_tests++;
        if (outs !== 11'd0) begin
            n_fail++; $display("FAIL loss_outputs_forced: got %h required 0", outs);
        end
    endtask

    task automatic test_priority();
        int slips;
        do_reset();
        slips = 0;
        for (int n = 1; n <= SEARCH_WIN + 2; n++) begin
            step((n >= SEARCH_WIN - TOKEN_RUN) ? tok_tab[0] : rand_data());
            if (bitslip) slips++;
        end
        n_tests++;
        if (slips !== 0) begin
            n_fail++; $display("FAIL prio_no_slip: got %0d pulses required 0", slips);
        end
        n_tests++;
        if (aligned !== 1'b1 || slip_cnt !== 4'd0) begin
            n_fail++; $display("FAIL prio_locked: aligned=%0b slip_cnt=%0d required 1 and 0", aligned, slip_cnt);
        end
    endtask

    task automatic test_reset_midop();
        logic seen;
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                seen = 1'b0;
                for (int k = 0; k < SEARCH_WIN + 10 && !seen; k++) begin
                    step(rand_data());
                    if (bitslip) seen = 1'b1;
                end
                repeat (3) step(rand_data());
                n_tests++;
                if (seen !== 1'b1 || slip_cnt !== 4'd1) begin
                    n_fail++; $display("FAIL midop_slip_wait_entry: seen=%0b slip_cnt=%0d required 1 and 1", seen, slip_cnt);
                end
            end else begin
                repeat (4) step(enc(8'hA5, 1'b1, 1'b0));
                n_tests++;
                if ({pdata, active, aligned} !== {8'hA5, 1'b1, 1'b1}) begin
                    n_fail++; $display("FAIL midop_locked_data: pdata=%h active=%b aligned=%b required a5 1 1", pdata, active, aligned);
                end
            end
            #2;
            resetn = 1'b0;
            #1;
            n_tests++;
            if ({pdata, ctl, active, aligned, bitslip, slip_cnt} !== 17'd0) begin
                n_fail++;
                $display("FAIL midop_reset_phase%0d: outputs=%h required 0", phase, {pdata, ctl, active, aligned, bitslip, slip_cnt});
            end
            @(posedge pixel_clk);
            #1;
            resetn = 1'b1;
            cyc    = 0;
            for (int k = 1; k <= TOKEN_RUN + 1; k++) begin
                step(tok_tab[0]);
                if (k == TOKEN_RUN) begin
                    n_tests++;
                    if (aligned !== 1'b0) begin
                        n_fail++; $display("FAIL midop_early_lock_phase%0d: aligned=%0b required 0", phase, aligned);
                    end
                end
            end
            n_tests++;
            if (aligned !== 1'b1) begin
                n_fail++; $display("FAIL midop_relock_phase%0d: aligned=%0b required 1", phase, aligned);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        resetn    = 1'b1;
        tmds_data = '0;
        test_reset();
        test_aligned_lock();
        test_decode_table();
        test_slip_search();
        test_lock_loss();
        test_priority();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL sim_time_limit: run exceeded 1500000 ns without finishing");
        $fatal(1, "simulation time limit reached");
    end

endmodule
